ws2812_rx: RTL and testbench

// - Receive-side decoder for the WS2812 single-wire LED protocol: measures high-pulse widths on din,

---
 rtl/ws2812_rx.sv | 162 ++++++++++++++++
 tb/tb_ws2812_rx.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ws2812_rx.sv
// WS2812 receive decoder: measures din high widths, assembles 24-bit GRB pixels, flags latch gaps.
// Optional chained-LED forwarding on dout is enabled by defining WS2812_RX_FWD_EN.
module ws2812_rx #(
    parameter int CLK_MHZ  = 50,
    parameter int GLITCH   = CLK_MHZ / 10,
    parameter int BIT_THR  = (CLK_MHZ * 6) / 10,
    parameter int MAX_HIGH = (CLK_MHZ * 12) / 10,
    parameter int RST_CYC  = CLK_MHZ * 50
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        din,
    output logic [23:0] pix_data,
    output logic        pix_valid,
    output logic [6:0]  pix_idx,
    output logic        frame_done,
    output logic        err,
    output logic        dout
);

    localparam logic [11:0] GLITCH_C  = 12'(GLITCH);
    localparam logic [11:0] BIT_THR_C = 12'(BIT_THR);
    localparam logic [11:0] MAX_C     = 12'(MAX_HIGH);
    localparam logic [11:0] RST_C     = 12'(RST_CYC);
    localparam logic [11:0] CNT_MAX   = 12'hFFF;
    localparam logic [7:0]  PIX_SAT   = 8'd128;

    typedef enum logic [1:0] {SYNC, IDLE, HIGH, LOW} state_t;

    state_t      state, state_next;
    logic        din_m, din_s, din_d;
    logic        rise, fall;
    logic [11:0] high_cnt, low_cnt;
    logic [4:0]  bit_cnt;
    logic [23:0] shreg, shreg_next;
    logic [7:0]  pix_cnt;
    logic        start_high, shift_en, long_err, gap;
    logic        bit_val, pix_done;

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            din_m <= 1'b0;
            din_s <= 1'b0;
            din_d <= 1'b0;
        end else begin
            din_m <= din;
            din_s <= din_m;
            din_d <= din_s;
        end
    end

    assign rise       = din_s & ~din_d;
    assign fall       = ~din_s & din_d;
    assign bit_val    = (high_cnt >= BIT_THR_C);
    assign shreg_next = {shreg[22:0], bit_val};
    assign pix_done   = shift_en && (bit_cnt == 5'd23);

    always_ff @(posedge sys_clk) begin
        if (sys_rst) state <= SYNC;
        else         state <= state_next;
    end

    always_comb begin
        state_next = state;
        start_high = 1'b0;
        shift_en   = 1'b0;
        long_err   = 1'b0;
        gap        = 1'b0;
        case (state)
            SYNC: if (!din_s && low_cnt >= RST_C) state_next = IDLE;
            IDLE: if (rise) begin
                start_high = 1'b1;
                state_next = HIGH;
            end
            HIGH: if (high_cnt > MAX_C) begin
                long_err   = 1'b1;
                state_next = SYNC;
            end else if (fall) begin
                shift_en   = (high_cnt >= GLITCH_C);
                state_next = LOW;
            end
            LOW: if (rise) begin
                start_high = 1'b1;
                state_next = HIGH;
            end else if (low_cnt >= RST_C) begin
                gap        = 1'b1;
                state_next = IDLE;
            end
            default: state_next = SYNC;
        endcase
    end

    // The falling-edge cycle is the first low sample, so the low count restarts at 1 there.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            high_cnt   <= '0;
            low_cnt    <= '0;
            bit_cnt    <= '0;
            shreg      <= '0;
            pix_cnt    <= '0;
            pix_data   <= '0;
            pix_idx    <= '0;
            pix_valid  <= 1'b0;
            frame_done <= 1'b0;
            err        <= 1'b0;
        end else begin
            pix_valid  <= 1'b0;
            frame_done <= 1'b0;
            err        <= 1'b0;

            if (start_high)                          high_cnt <= 12'd1;
            else if (din_s && high_cnt != CNT_MAX)   high_cnt <= high_cnt + 12'd1;

            if (long_err || din_s)                   low_cnt <= '0;
            else if (state == HIGH)                  low_cnt <= 12'd1;
            else if (low_cnt != CNT_MAX)             low_cnt <= low_cnt + 12'd1;

            if (long_err) begin
                err     <= 1'b1;
                bit_cnt <= '0;
                shreg   <= '0;
                pix_cnt <= '0;
            end else if (gap) begin
                err        <= (bit_cnt != 5'd0);
                frame_done <= (pix_cnt != 8'd0);
                bit_cnt    <= '0;
                shreg      <= '0;
                pix_cnt    <= '0;
            end else if (shift_en) begin
                shreg <= shreg_next;
                if (pix_done) begin
                    bit_cnt   <= '0;
                    pix_data  <= shreg_next;
                    pix_valid <= 1'b1;
                    pix_idx   <= pix_cnt[7] ? 7'd127 : pix_cnt[6:0];
                    if (pix_cnt != PIX_SAT) pix_cnt <= pix_cnt + 8'd1;
                end else begin
                    bit_cnt <= bit_cnt + 5'd1;
                end
            end
        end
    end

`ifdef WS2812_RX_FWD_EN
    logic fwd;

    // Pixel 0 is consumed here; everything after it is passed down the chain.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            fwd  <= 1'b0;
            dout <= 1'b0;
        end else begin
            if (long_err || gap)                  fwd <= 1'b0;
            else if (pix_done && pix_cnt == 8'd0) fwd <= 1'b1;
            dout <= din_s & fwd;
        end
    end
`else
    assign dout = 1'b0;
`endif

endmodule

// File: tb/tb_ws2812_rx.sv
// Directed testbench for ws2812_rx: drives WS2812 waveforms on din and checks decoded pixels and flags.
// Define WS2812_RX_FWD_EN to also exercise the forwarding output.
module tb_ws2812_rx;

    logic        sys_clk = 1'b0;
    logic        sys_rst = 1'b1;
    logic        din     = 1'b0;
    logic [23:0] pix_data;
    logic        pix_valid;
    logic [6:0]  pix_idx;
    logic        frame_done;
    logic        err;
    logic        dout;

    int n_checks = 0;
    int n_errors = 0;

    int          valid_cnt = 0;
    int          fd_cnt    = 0;
    int          err_cnt   = 0;
    int          both_cnt  = 0;
    int          dout_hi   = 0;
    int          dout_rise = 0;
    logic        dout_prev = 1'b0;
    logic [23:0] last_data = '0;
    logic [6:0]  last_idx  = '0;

    always #5 sys_clk = ~sys_clk;

    ws2812_rx dut (
        .sys_clk    (sys_clk),
        .sys_rst    (sys_rst),
        .din        (din),
        .pix_data   (pix_data),
        .pix_valid  (pix_valid),
        .pix_idx    (pix_idx),
        .frame_done (frame_done),
        .err        (err),
        .dout       (dout)
    );

    // Event monitor on the falling clock edge, well away from the active edge.
    always @(negedge sys_clk) begin
        if (pix_valid) begin
            valid_cnt++;
            last_data = pix_data;
            last_idx  = pix_idx;
        end
        if (frame_done)        fd_cnt++;
        if (err)               err_cnt++;
        if (err && frame_done) both_cnt++;
        if (dout === 1'b1)     dout_hi++;
        if (dout === 1'b1 && dout_prev !== 1'b1) dout_rise++;
        dout_prev = dout;
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge sys_clk);
        #1;
    endtask

    task automatic clear_mon();
        valid_cnt = 0;
        fd_cnt    = 0;
        err_cnt   = 0;
        both_cnt  = 0;
        dout_hi   = 0;
        dout_rise = 0;
    endtask

    task automatic send_bit(input logic b, input int th, input int period);
        din = 1'b1;
        cyc(th);
        din = 1'b0;
        cyc(period - th);
    endtask

    task automatic send_bits(input logic [23:0] d, input int n, input int period);
        logic b;
        for (int i = 0; i < n; i++) begin
            b = d[23 - i];
            send_bit(b, b ? 40 : 20, period);
        end
    endtask

    task automatic send_gap();
        din = 1'b0;
        cyc(2508);
    endtask

    function automatic int pulse_sum(input logic [23:0] d);
        int s = 0;
        for (int i = 0; i < 24; i++) s += d[i] ? 40 : 20;
        return s;
    endfunction

    task automatic test_reset();
        sys_rst = 1'b1;
        din     = 1'b0;
        cyc(3);
        n_checks++; if (pix_data !== 24'h0) begin n_errors++; $display("[TB] FAIL reset_pix_data: got %h expected 000000", pix_data); end
        n_checks++; if (pix_valid !== 1'b0) begin n_errors++; $display("[TB] FAIL reset_pix_valid: got %b expected 0", pix_valid); end
        n_checks++; if (pix_idx !== 7'd0) begin n_errors++; $display("[TB] FAIL reset_pix_idx: got %0d expected 0", pix_idx); end
        n_checks++; if (frame_done !== 1'b0) begin n_errors++; $display("[TB] FAIL reset_frame_done: got %b expected 0", frame_done); end
        n_checks++; if (err !== 1'b0) begin n_errors++; $display("[TB] FAIL reset_err: got %b expected 0", err); end
        n_checks++; if (dout !== 1'b0) begin n_errors++; $display("[TB] FAIL reset_dout: got %b expected 0", dout); end
        sys_rst = 1'b0;
        cyc(1);
    endtask

    task automatic test_first_pixel();
        send_gap();
        clear_mon();
        send_bits(24'hA53C0F, 23, 62);
        din = 1'b1;
        cyc(40);
        din = 1'b0;
        repeat (2) @(posedge sys_clk);
        #1;
        n_checks++; if (pix_valid !== 1'b0) begin n_errors++; $display("[TB] FAIL latency_early: got %b expected 0", pix_valid); end
        @(posedge sys_clk);
        #1;
        n_checks++; if (pix_valid !== 1'b1) begin n_errors++; $display("[TB] FAIL latency_3cyc: got %b expected 1", pix_valid); end
        cyc(19);
        n_checks++; if (valid_cnt !== 1) begin n_errors++; $display("[TB] FAIL first_valid_cnt: got %0d expected 1", valid_cnt); end
        n_checks++; if (last_data !== 24'hA53C0F) begin n_errors++; $display("[TB] FAIL first_data: got %h expected a53c0f", last_data); end
        n_checks++; if (last_idx !== 7'd0) begin n_errors++; $display("[TB] FAIL first_idx: got %0d expected 0", last_idx); end
        send_gap();
        n_checks++; if (fd_cnt !== 1) begin n_errors++; $display("[TB] FAIL first_frame_done: got %0d expected 1", fd_cnt); end
    endtask

    task automatic test_multi_pixel();
        logic [23:0] px [3];
        px[0] = 24'hFF0000;
        px[1] = 24'h00FF00;
        px[2] = 24'h0000FF;
        clear_mon();
        for (int k = 0; k < 3; k++) begin
            send_bits(px[k], 24, 44);
            n_checks++; if (last_data !== px[k]) begin n_errors++; $display("[TB] FAIL multi_data%0d: got %h expected %h", k, last_data, px[k]); end
            n_checks++; if (last_idx !== 7'(k)) begin n_errors++; $display("[TB] FAIL multi_idx%0d: got %0d expected %0d", k, last_idx, k); end
        end
        n_checks++; if (fd_cnt !== 0) begin n_errors++; $display("[TB] FAIL multi_early_done: got %0d expected 0", fd_cnt); end
        send_gap();
        n_checks++; if (fd_cnt !== 1) begin n_errors++; $display("[TB] FAIL multi_frame_done: got %0d expected 1", fd_cnt); end
        n_checks++; if (err_cnt !== 0) begin n_errors++; $display("[TB] FAIL multi_err: got %0d expected 0", err_cnt); end
`ifndef WS2812_RX_FWD_EN
        n_checks++; if (dout_hi !== 0) begin n_errors++; $display("[TB] FAIL dout_tied_low: got %0d high cycles expected 0", dout_hi); end
`endif
    endtask

    task automatic test_pre_gap_activity();
        sys_rst = 1'b1;
        cyc(2);
        sys_rst = 1'b0;
        clear_mon();
        send_bits(24'hC0FFEE, 24, 44);
        n_checks++; if (valid_cnt !== 0) begin n_errors++; $display("[TB] FAIL pregap_valid: got %0d expected 0", valid_cnt); end
        send_gap();
        n_checks++; if (fd_cnt !== 0) begin n_errors++; $display("[TB] FAIL pregap_done: got %0d expected 0", fd_cnt); end
        send_bits(24'h13579B, 24, 44);
        n_checks++; if (valid_cnt !== 1) begin n_errors++; $display("[TB] FAIL pregap_after_valid: got %0d expected 1", valid_cnt); end
        n_checks++; if (last_data !== 24'h13579B) begin n_errors++; $display("[TB] FAIL pregap_after_data: got %h expected 13579b", last_data); end
        send_gap();
    endtask

    task automatic test_partial_pixel();
        clear_mon();
        send_bits(24'hABC000, 12, 44);
        send_gap();
        n_checks++; if (err_cnt !== 1) begin n_errors++; $display("[TB] FAIL partial_err: got %0d expected 1", err_cnt); end
        n_checks++; if (valid_cnt !== 0) begin n_errors++; $display("[TB] FAIL partial_valid: got %0d expected 0", valid_cnt); end
        n_checks++; if (fd_cnt !== 0) begin n_errors++; $display("[TB] FAIL partial_done: got %0d expected 0", fd_cnt); end
        clear_mon();
        send_bits(24'h6B1D2E, 24, 44);
        send_gap();
        n_checks++; if (last_data !== 24'h6B1D2E) begin n_errors++; $display("[TB] FAIL partial_next_data: got %h expected 6b1d2e", last_data); end
        n_checks++; if (fd_cnt !== 1 || err_cnt !== 0) begin n_errors++; $display("[TB] FAIL partial_next_flags: got done=%0d err=%0d expected done=1 err=0", fd_cnt, err_cnt); end
    endtask

    task automatic test_err_and_done();
        clear_mon();
        send_bits(24'h112233, 24, 44);
        send_bits(24'h445566, 12, 44);
        send_gap();
        n_checks++; if (valid_cnt !== 1) begin n_errors++; $display("[TB] FAIL both_valid: got %0d expected 1", valid_cnt); end
        n_checks++; if (both_cnt !== 1) begin n_errors++; $display("[TB] FAIL both_same_cycle: got %0d expected 1", both_cnt); end
        n_checks++; if (err_cnt !== 1 || fd_cnt !== 1) begin n_errors++; $display("[TB] FAIL both_counts: got err=%0d done=%0d expected 1/1", err_cnt, fd_cnt); end
    endtask

    task automatic test_long_pulse();
        clear_mon();
        send_bits(24'hF0F0F0, 8, 44);
        din = 1'b1;
        cyc(80);
        din = 1'b0;
        cyc(30);
        n_checks++; if (err_cnt !== 1) begin n_errors++; $display("[TB] FAIL long_err: got %0d expected 1", err_cnt); end
        send_bits(24'h00FF00, 24, 44);
        n_checks++; if (valid_cnt !== 0) begin n_errors++; $display("[TB] FAIL long_sync_ignore: got %0d expected 0", valid_cnt); end
        send_gap();
        n_checks++; if (fd_cnt !== 0) begin n_errors++; $display("[TB] FAIL long_sync_done: got %0d expected 0", fd_cnt); end
        send_bits(24'h2468AC, 24, 44);
        n_checks++; if (last_data !== 24'h2468AC || last_idx !== 7'd0) begin n_errors++; $display("[TB] FAIL long_recover: got %h idx %0d expected 2468ac idx 0", last_data, last_idx); end
        send_gap();
    endtask

    task automatic test_glitch();
        logic [23:0] d;
        d = 24'h9C63E1;
        clear_mon();
        send_bits(d, 12, 44);
        din = 1'b1;
        cyc(3);
        din = 1'b0;
        cyc(20);
        send_bits({d[11:0], 12'h000}, 12, 44);
        n_checks++; if (valid_cnt !== 1 || last_data !== 24'h9C63E1) begin n_errors++; $display("[TB] FAIL glitch_ignored: got %0d pixels data %h expected 1 pixel 9c63e1", valid_cnt, last_data); end
        n_checks++; if (err_cnt !== 0) begin n_errors++; $display("[TB] FAIL glitch_err: got %0d expected 0", err_cnt); end
        send_gap();
    endtask

    task automatic test_idx_saturation();
        clear_mon();
        for (int k = 0; k < 130; k++) begin
            for (int b = 0; b < 24; b++) send_bit(1'b0, 5, 9);
            if (k == 126) begin
                n_checks++; if (last_idx !== 7'd126) begin n_errors++; $display("[TB] FAIL sat_idx126: got %0d expected 126", last_idx); end
            end
        end
        n_checks++; if (valid_cnt !== 130) begin n_errors++; $display("[TB] FAIL sat_valid_cnt: got %0d expected 130", valid_cnt); end
        n_checks++; if (last_idx !== 7'd127) begin n_errors++; $display("[TB] FAIL sat_idx_last: got %0d expected 127", last_idx); end
        n_checks++; if (last_data !== 24'h000000) begin n_errors++; $display("[TB] FAIL sat_data: got %h expected 000000", last_data); end
        send_gap();
        n_checks++; if (fd_cnt !== 1) begin n_errors++; $display("[TB] FAIL sat_done: got %0d expected 1", fd_cnt); end
    endtask

    task automatic test_reset_mid();
        clear_mon();
        send_bits(24'h123456, 24, 44);
        send_bits(24'hFEDCBA, 12, 44);
        sys_rst = 1'b1;
        cyc(2);
        n_checks++; if (pix_data !== 24'h0 || pix_idx !== 7'd0) begin n_errors++; $display("[TB] FAIL midreset_outputs: got %h idx %0d expected 000000 idx 0", pix_data, pix_idx); end
        sys_rst = 1'b0;
        send_gap();
        send_bits(24'h0A0B0C, 24, 44);
        send_gap();
        n_checks++; if (last_data !== 24'h0A0B0C || last_idx !== 7'd0) begin n_errors++; $display("[TB] FAIL midreset_next: got %h idx %0d expected 0a0b0c idx 0", last_data, last_idx); end
        n_checks++; if (err_cnt !== 0 || fd_cnt !== 1) begin n_errors++; $display("[TB] FAIL midreset_flags: got err=%0d done=%0d expected 0/1", err_cnt, fd_cnt); end
    endtask

`ifdef WS2812_RX_FWD_EN
    task automatic test_forward();
        clear_mon();
        send_bits(24'hA53C0F, 24, 44);
        n_checks++; if (dout_hi !== 0) begin n_errors++; $display("[TB] FAIL fwd_pixel0: got %0d high cycles expected 0", dout_hi); end
        clear_mon();
        send_bits(24'h5A00FF, 24, 44);
        n_checks++; if (dout_hi !== pulse_sum(24'h5A00FF)) begin n_errors++; $display("[TB] FAIL fwd_widths: got %0d expected %0d", dout_hi, pulse_sum(24'h5A00FF)); end
        n_checks++; if (dout_rise !== 24) begin n_errors++; $display("[TB] FAIL fwd_pulses: got %0d expected 24", dout_rise); end
        send_gap();
        clear_mon();
        send_bits(24'h3C3C3C, 24, 44);
        n_checks++; if (dout_hi !== 0) begin n_errors++; $display("[TB] FAIL fwd_after_gap: got %0d expected 0", dout_hi); end
        send_gap();
    endtask
`endif

    initial begin
        test_reset();
        test_first_pixel();
        test_multi_pixel();
        test_pre_gap_activity();
        test_partial_pixel();
        test_err_and_done();
        test_long_pulse();
        test_glitch();
        test_idx_saturation();
        test_reset_mid();
`ifdef WS2812_RX_FWD_EN
        test_forward();
`endif
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
